zpu_sd_bridge: RTL and testbench

Bridges the ZPU firmware I/O registers of `atari5200top` to the `hps_io` SD block interface for cartridge loading. It owns the 512-byte sector buffer, the LBA and file-size registers, mount tracking and the block read/write request handshake. It sits between `hps_io` (SD side) and the ZPU_IN2/IN3/OUT2/OUT3/RD/WR ports of `atari5200top`, in the `clk_sys` domain.

---
 rtl/zpu_sd_bridge_pkg.sv | 29 ++
 rtl/zpu_sd_bridge_if.sv | 28 ++
 rtl/zpu_sd_bridge_dpram.sv | 27 ++
 rtl/zpu_sd_bridge.sv | 161 ++++++++++++++++
 tb/tb_zpu_sd_bridge.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/zpu_sd_bridge_pkg.sv
// Shared ZPU I/O register field positions and the block-request state encoding.
package zpu_io_pkg;

  // ZPU_OUT2 control bits
  localparam int OUT2_LBA_SEL  = 0;
  localparam int OUT2_BLOCK_RD = 1;
  localparam int OUT2_BLOCK_WR = 2;

  // ZPU_WR strobe bits
  localparam int WR_IO   = 5;
  localparam int WR_DATA = 6;

  // ZPU_RD strobe bits
  localparam int RD_DATA = 2;

  // ZPU_IN2 status field positions
  localparam int IN2_IO_DONE      = 0;
  localparam int IN2_MOUNTED      = 1;
  localparam int IN2_FILENO_LSB   = 2;
  localparam int IN2_FILETYPE_LSB = 5;
  localparam int IN2_READONLY     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } req_state_t;

endpackage

// File: rtl/zpu_sd_bridge_if.sv
// hps_io SD block interface as seen by the bridge (master) and by hps_io (slave).
interface zpu_sd_bridge_if #(
  parameter int BUF_AW = 9
);
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [BUF_AW-1:0] sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic              img_mounted;
  logic [63:0]       img_size;
  logic [7:0]        ioctl_index;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           img_mounted, img_size, ioctl_index
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           img_mounted, img_size, ioctl_index
  );
endinterface

// File: rtl/zpu_sd_bridge_dpram.sv
// True dual-port RAM with registered read data on both ports.
module dpram #(
  parameter int widthad_a = 9,
  parameter int width_a   = 8
) (
  input  logic                 clock,
  input  logic [widthad_a-1:0] address_a,
  input  logic [width_a-1:0]   data_a,
  input  logic                 wren_a,
  output logic [width_a-1:0]   q_a,
  input  logic [widthad_a-1:0] address_b,
  input  logic [width_a-1:0]   data_b,
  input  logic                 wren_b,
  output logic [width_a-1:0]   q_b
);

  logic [width_a-1:0] mem [2**widthad_a];

  // Both ports write and read on the same clock; reads return the pre-write contents
  always_ff @(posedge clock) begin
    if (wren_a) mem[address_a] <= data_a;
    if (wren_b) mem[address_b] <= data_b;
    q_a <= mem[address_a];
    q_b <= mem[address_b];
  end

endmodule

// File: rtl/zpu_sd_bridge.sv
// ZPU firmware register bridge to the hps_io SD block interface: sector buffer,
// LBA/file-size registers, mount tracking and block request handshake.
module zpu_sd_bridge
  import zpu_io_pkg::*;
#(
  parameter int BUF_AW = 9
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [31:0] zpu_out2,
  input  logic [31:0] zpu_out3,
  input  logic [15:0] zpu_wr,
  input  logic [15:0] zpu_rd,
  output logic [7:0]  zpu_in2,
  output logic [31:0] zpu_in3,
  zpu_sd_bridge_if.master sd
);

  logic lba_sel, io_wr;
  assign lba_sel = zpu_out2[OUT2_LBA_SEL];
  assign io_wr   = zpu_wr[WR_IO];

  // Input history; the first flop is the synchroniser, the second gives the edge
  logic data_wr_p0, data_wr_p1, data_rd_p0;
  logic block_rd_p0, block_rd_p1, block_wr_p0, block_wr_p1;
  logic ack_p0, ack_p1, mnt_p0, mnt_p1;

  logic wr_rise, rd_fall, brd_rise, bwr_rise, ack_fall, mnt_rise;
  assign wr_rise  = data_wr_p0 & ~data_wr_p1;
  assign rd_fall  = data_rd_p0 & ~zpu_rd[RD_DATA];
  assign brd_rise = block_rd_p0 & ~block_rd_p1;
  assign bwr_rise = block_wr_p0 & ~block_wr_p1;
  assign ack_fall = ~ack_p0 & ack_p1;
  assign mnt_rise = mnt_p0 & ~mnt_p1;

  logic              buf_we;
  logic [BUF_AW-1:0] buf_addr;
  logic [31:0]       lba_q;
  logic [7:0]        buf_q;
  logic [7:0]        buf_din;
  logic [2:0]        fileno;
  logic [1:0]        filetype;
  logic              readonly, mounted;
  logic [31:0]       filesize;
  req_state_t        state, state_nxt;
  logic              req_wr;

  // Edge history; reset preloads current inputs so release creates no edges
  always_ff @(posedge clk_sys) begin
    data_wr_p0  <= zpu_wr[WR_DATA];
    data_rd_p0  <= zpu_rd[RD_DATA];
    block_rd_p0 <= zpu_out2[OUT2_BLOCK_RD];
    block_wr_p0 <= zpu_out2[OUT2_BLOCK_WR];
    ack_p0      <= sd.sd_ack;
    mnt_p0      <= sd.img_mounted;
    if (!reset_n) begin
      data_wr_p1  <= zpu_wr[WR_DATA];
      block_rd_p1 <= zpu_out2[OUT2_BLOCK_RD];
      block_wr_p1 <= zpu_out2[OUT2_BLOCK_WR];
      ack_p1      <= sd.sd_ack;
      mnt_p1      <= sd.img_mounted;
    end else begin
      data_wr_p1  <= data_wr_p0;
      block_rd_p1 <= block_rd_p0;
      block_wr_p1 <= block_wr_p0;
      ack_p1      <= ack_p0;
      mnt_p1      <= mnt_p0;
    end
  end

  // ZPU data writes go to the LBA or the buffer; buffer address walks on writes and reads
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      buf_we   <= 1'b0;
      buf_addr <= '0;
      lba_q    <= '0;
    end else begin
      buf_we <= wr_rise & ~lba_sel;
      if (wr_rise && lba_sel) lba_q <= zpu_out3;
      if (io_wr)                 buf_addr <= '0;
      else if (buf_we || rd_fall) buf_addr <= buf_addr + 1'b1;
    end
  end

  // Mount tracking; a mount event is accepted regardless of request state
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      fileno   <= '0;
      filetype <= '0;
      readonly <= 1'b1;
      mounted  <= |sd.img_size[31:0];
      filesize <= '0;
    end else if (mnt_rise) begin
      fileno   <= '0;
      filetype <= sd.ioctl_index[7:6];
      readonly <= 1'b1;
      mounted  <= ~mounted;
      filesize <= sd.img_size[31:0];
    end
  end

  // Request FSM state register; also latches whether the pending request is a write
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state  <= IDLE;
      req_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (brd_rise || bwr_rise)) req_wr <= ~brd_rise;
    end
  end

  // Request FSM next state; read wins over a simultaneous write request
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (brd_rise || bwr_rise) state_nxt = REQ;
      REQ:     if (ack_p0)               state_nxt = XFER;
      XFER:    if (ack_fall)             state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Request FSM outputs and status word
  always_comb begin
    sd.sd_rd = 1'b0;
    sd.sd_wr = 1'b0;
    zpu_in2  = '0;
    if (state == REQ) begin
      sd.sd_rd = ~req_wr;
      sd.sd_wr = req_wr;
    end
    zpu_in2[IN2_IO_DONE]                = (state == IDLE);
    zpu_in2[IN2_MOUNTED]                = mounted;
    zpu_in2[IN2_FILENO_LSB +: 3]        = fileno;
    zpu_in2[IN2_FILETYPE_LSB +: 2]      = filetype;
    zpu_in2[IN2_READONLY]               = readonly;
  end

  assign zpu_in3        = lba_sel ? filesize : {24'b0, buf_q};
  assign sd.sd_lba      = lba_q;
  assign sd.sd_buff_din = buf_din;

  dpram #(BUF_AW, 8) u_buf (
    .clock     (clk_sys),
    .address_a (sd.sd_buff_addr),
    .data_a    (sd.sd_buff_dout),
    .wren_a    (sd.sd_buff_wr),
    .q_a       (buf_din),
    .address_b (buf_addr),
    .data_b    (zpu_out3[7:0]),
    .wren_b    (buf_we),
    .q_b       (buf_q)
  );

  logic unused_bits;
  assign unused_bits = ^{zpu_out2[31:3], zpu_wr[15:7], zpu_wr[4:0],
                         zpu_rd[15:3], zpu_rd[1:0], sd.img_size[63:32],
                         sd.ioctl_index[5:0]};

endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Directed bench for zpu_sd_bridge: registers, sector buffer, request handshake, mount.
module tb_zpu_sd_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [31:0] zpu_out2, zpu_out3;
  logic [15:0] zpu_wr, zpu_rd;
  logic [7:0]  zpu_in2;
  logic [31:0] zpu_in3;

  int n_checks = 0;
  int n_errors = 0;

  zpu_sd_bridge_if #(.BUF_AW(9)) sd ();

  zpu_sd_bridge #(.BUF_AW(9)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .zpu_out2 (zpu_out2),
    .zpu_out3 (zpu_out3),
    .zpu_wr   (zpu_wr),
    .zpu_rd   (zpu_rd),
    .zpu_in2  (zpu_in2),
    .zpu_in3  (zpu_in3),
    .sd       (sd.master)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic data_rd_pulse();
    zpu_rd[2] = 1'b1;
    tick();
    zpu_rd[2] = 1'b0;
    tick();
  endtask

  task automatic io_wr_pulse();
    zpu_wr[5] = 1'b1;
    tick();
    zpu_wr[5] = 1'b0;
    tick();
  endtask

  int hps_addr [6] = '{0, 1, 255, 256, 300, 511};

  initial begin
    reset_n         = 1'b0;
    zpu_out2        = '0;
    zpu_out3        = '0;
    zpu_wr          = '0;
    zpu_rd          = '0;
    sd.sd_ack       = 1'b0;
    sd.sd_buff_addr = '0;
    sd.sd_buff_dout = '0;
    sd.sd_buff_wr   = 1'b0;
    sd.img_mounted  = 1'b0;
    sd.img_size     = 64'h2000;
    sd.ioctl_index  = '0;
    tick(3);
    reset_n = 1'b1;
    tick();
    check("rst_in2", 32'(zpu_in2), 'h83);
    check("rst_addr", 32'(dut.buf_addr), 0);
    check("rst_sd_rd", 32'(sd.sd_rd), 0);
    check("rst_sd_wr", 32'(sd.sd_wr), 0);
    check("rst_lba", sd.sd_lba, 0);

    // LBA write: visible two edges after the strobe is first sampled
    zpu_out2  = 32'h1;
    zpu_out3  = 32'h1234;
    zpu_wr[6] = 1'b1;
    tick();
    check("lba_early", sd.sd_lba, 0);
    tick();
    check("lba_set", sd.sd_lba, 'h1234);
    zpu_wr[6] = 1'b0;
    tick(2);
    check("lba_addr", 32'(dut.buf_addr), 0);
    check("filesize_rst", zpu_in3, 0);

    // Read strobe falling edge advances the address; io_wr clears it
    zpu_out2 = '0;
    data_rd_pulse();
    check("rd_inc", 32'(dut.buf_addr), 1);
    io_wr_pulse();
    check("io_clr", 32'(dut.buf_addr), 0);

    // Fill the whole buffer from the ZPU side
    for (int i = 0; i < 512; i++) begin
      zpu_out3  = 32'(i & 255);
      zpu_wr[6] = 1'b1;
      tick();
      zpu_wr[6] = 1'b0;
      tick(3);
    end
    check("fill_wrap", 32'(dut.buf_addr), 0);
    for (int k = 0; k < 6; k++) begin
      sd.sd_buff_addr = 9'(hps_addr[k]);
      tick();
      check($sformatf("hps_rd_%0d", hps_addr[k]), 32'(sd.sd_buff_din), 32'(hps_addr[k] & 255));
    end
    check("zpu_rd0", zpu_in3, 0);
    data_rd_pulse();
    tick();
    check("zpu_rd1", zpu_in3, 1);

    // Block read with hps_io writing 0xA5 into the first 8 bytes
    io_wr_pulse();
    zpu_out2 = 32'h2;
    tick(2);
    check("brd_sd_rd", 32'(sd.sd_rd), 1);
    check("brd_sd_wr", 32'(sd.sd_wr), 0);
    check("brd_busy", 32'(zpu_in2[0]), 0);
    sd.sd_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sd.sd_buff_addr = 9'(i);
      sd.sd_buff_dout = 8'hA5;
      sd.sd_buff_wr   = 1'b1;
      tick();
    end
    sd.sd_buff_wr = 1'b0;
    sd.sd_ack     = 1'b0;
    check("brd_rd_drop", 32'(sd.sd_rd), 0);
    tick();
    check("brd_still_busy", 32'(zpu_in2[0]), 0);
    tick();
    check("brd_done", 32'(zpu_in2[0]), 1);
    zpu_out2 = '0;
    tick(2);
    check("brd_byte0", zpu_in3, 'hA5);
    data_rd_pulse();
    tick();
    check("brd_byte1", zpu_in3, 'hA5);

    // Simultaneous rd/wr request: read wins; a new block_rd during XFER is ignored
    zpu_out2 = 32'h6;
    tick(2);
    check("both_sd_rd", 32'(sd.sd_rd), 1);
    check("both_sd_wr", 32'(sd.sd_wr), 0);
    sd.sd_ack = 1'b1;
    tick(2);
    check("both_rd_drop", 32'(sd.sd_rd), 0);
    zpu_out2 = '0;
    tick(2);
    zpu_out2 = 32'h2;
    tick(2);
    sd.sd_ack = 1'b0;
    tick(2);
    check("both_done", 32'(zpu_in2[0]), 1);
    tick(2);
    check("xfer_rd_ignored", 32'(sd.sd_rd), 0);

    // Block write, then reset while in XFER
    zpu_out2 = 32'h4;
    tick(2);
    check("bwr_sd_wr", 32'(sd.sd_wr), 1);
    check("bwr_sd_rd", 32'(sd.sd_rd), 0);
    sd.sd_ack = 1'b1;
    tick(2);
    check("bwr_wr_drop", 32'(sd.sd_wr), 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("abort_in2", 32'(zpu_in2), 'h83);
    check("abort_lba", sd.sd_lba, 0);
    sd.sd_ack = 1'b0;
    tick(2);
    check("abort_done", 32'(zpu_in2[0]), 1);
    check("abort_no_wr", 32'(sd.sd_wr), 0);
    check("abort_no_rd", 32'(sd.sd_rd), 0);

    // Mount events toggle mounted and capture filetype/filesize
    zpu_out2       = '0;
    sd.ioctl_index = 8'h40;
    sd.img_size    = 64'h8000;
    sd.img_mounted = 1'b1;
    tick();
    sd.img_mounted = 1'b0;
    tick();
    check("mnt1_in2", 32'(zpu_in2), 'hA1);
    zpu_out2 = 32'h1;
    #1;
    check("mnt1_size", zpu_in3, 'h8000);
    sd.ioctl_index = 8'hC0;
    sd.img_size    = 64'h1_0001_0000;
    sd.img_mounted = 1'b1;
    tick();
    sd.img_mounted = 1'b0;
    tick();
    check("mnt2_in2", 32'(zpu_in2), 'hE3);
    check("mnt2_size", zpu_in3, 'h1_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
